// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the camera test-pattern transmitter.
//   cam_state_e  - frame timing FSM states
//   cam_mode_e   - pattern select encodings (mode input)
//   BAR_*        - RGB565 colours of the eight colour bars, left to right
//   bar_color()  - maps a bar index (0..7) to its RGB565 colour
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } cam_state_e;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } cam_mode_e;

  // Width of the pixel coordinates handed to the pattern generator.
  localparam int unsigned COORD_W = 16;

  localparam int unsigned NUM_BARS = 8;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cam_pixel_gen.sv
// cam_pixel_gen: combinational pattern colour selection.
//   x_i        pixel column within the active line
//   y_i        active-line index within the frame
//   bar_idx_i  colour-bar index (0..7), maintained by the caller's counters
//   mode_i     pattern select
//   solid_i    RGB565 colour used in solid mode
//   rgb_o      RGB565 colour of the pixel at (x_i, y_i)
module cam_pixel_gen
  import cam_pkg::*;
(
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [2:0]         bar_idx_i,
  input  cam_mode_e          mode_i,
  input  logic [15:0]        solid_i,
  output logic [15:0]        rgb_o
);

  // Coordinate bits that no pattern looks at.
  logic unused_coord_bits;
  assign unused_coord_bits = ^{x_i[COORD_W-1:8], x_i[1:0], y_i[COORD_W-1:6], y_i[4:0]};

  always_comb begin
    rgb_o = '0;
    unique case (mode_i)
      MODE_BARS:  rgb_o = bar_color(bar_idx_i);
      // Column replicated into all three channels gives a grey ramp.
      MODE_GRAD:  rgb_o = {x_i[7:3], x_i[7:2], x_i[7:3]};
      // 32x32-pixel squares.
      MODE_CHECK: rgb_o = (x_i[5] ^ y_i[5]) ? '1 : '0;
      MODE_SOLID: rgb_o = solid_i;
      default:    rgb_o = '0;
    endcase
  end

endmodule

// File: rtl/cam_pattern_tx.sv
// cam_pattern_tx: emulates a parallel camera sensor emitting test patterns as an
// RGB565 byte stream (two bytes per pixel, one byte per clock).
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       level; while high, frames are produced back to back
//   mode         pattern select (bars / gradient / checkerboard / solid)
//   solid_color  RGB565 colour for solid mode
//   cam_vsync    high for the vsync lines of each frame
//   cam_href     high while an active line's bytes are valid
//   cam_data     byte stream, 8'h00 while cam_href is low
//   busy         high from frame start to frame end
//   frame_done   one-cycle pulse on the last cycle of a frame
module cam_pattern_tx
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned LINE_CYC  = 2 * (H_ACTIVE + H_BLANK);
  localparam int unsigned BYTE_W    = $clog2(LINE_CYC);
  localparam int unsigned MAX_VL    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int unsigned MAX_VA    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned MAX_LINES = (MAX_VL > MAX_VA) ? MAX_VL : MAX_VA;
  localparam int unsigned LINE_W    = $clog2(MAX_LINES + 1);
  localparam int unsigned COL_W     = $clog2(H_ACTIVE);
  localparam int unsigned BAR_PX    = H_ACTIVE / NUM_BARS;
  localparam int unsigned BAR_W     = (BAR_PX > 1) ? $clog2(BAR_PX) : 1;

  localparam logic [BYTE_W-1:0] BYTE_LAST   = BYTE_W'(LINE_CYC - 1);
  localparam logic [BYTE_W-1:0] HREF_END    = BYTE_W'(2 * H_ACTIVE);
  localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(H_ACTIVE - 1);
  localparam logic [BAR_W-1:0]  BAR_LAST    = BAR_W'(BAR_PX - 1);
  localparam logic [LINE_W-1:0] VFRONT_LAST = LINE_W'(V_FRONT - 1);

  cam_state_e        state_q,   state_d;
  logic [BYTE_W-1:0] byte_q,    byte_d;
  logic [LINE_W-1:0] line_q,    line_d;
  logic [COL_W-1:0]  col_q,     col_d;
  logic [BAR_W-1:0]  bar_px_q,  bar_px_d;
  logic [2:0]        bar_idx_q, bar_idx_d;
  cam_mode_e         mode_q,    mode_d;
  logic [15:0]       solid_q,   solid_d;

  logic              vsync_q,   vsync_d;
  logic              href_q,    href_d;
  logic [7:0]        data_q,    data_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  logic [LINE_W-1:0] lines_last;
  logic              last_byte;
  logic              last_line;
  logic [15:0]       rgb;

  // Index of the final line of the current state.
  always_comb begin
    lines_last = '0;
    unique case (state_q)
      ST_VSYNC:  lines_last = LINE_W'(VSYNC_LINES - 1);
      ST_VBACK:  lines_last = LINE_W'(V_BACK - 1);
      ST_ACTIVE: lines_last = LINE_W'(V_ACTIVE - 1);
      ST_VFRONT: lines_last = VFRONT_LAST;
      default:   lines_last = '0;
    endcase
  end

  assign last_byte = (byte_q == BYTE_LAST);
  assign last_line = (line_q == lines_last);

  // Next-state and counter logic.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    line_d    = line_q;
    col_d     = col_q;
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    mode_d    = mode_q;
    solid_d   = solid_q;

    if (state_q == ST_IDLE) begin
      // Counters are already zero in IDLE.
      if (enable) begin
        state_d = ST_VSYNC;
      end
    end else if (last_byte) begin
      byte_d    = '0;
      col_d     = '0;
      bar_px_d  = '0;
      bar_idx_d = '0;
      if (last_line) begin
        line_d = '0;
        unique case (state_q)
          ST_VSYNC:  state_d = ST_VBACK;
          ST_VBACK:  state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFRONT;
          ST_VFRONT: state_d = enable ? ST_VSYNC : ST_IDLE;
          default:   state_d = ST_IDLE;
        endcase
      end else begin
        line_d = line_q + 1'b1;
      end
    end else begin
      byte_d = byte_q + 1'b1;
      // Column advances after the second byte of each pixel and holds at the
      // last active pixel through blanking; the bar index rides along with a
      // pixel-in-bar counter instead of dividing the column.
      if (byte_q[0] && (col_q != COL_LAST)) begin
        col_d = col_q + 1'b1;
        if (bar_px_q == BAR_LAST) begin
          bar_px_d  = '0;
          bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_px_d = bar_px_q + 1'b1;
        end
      end
    end

    // Pattern settings are frozen for the whole frame at vsync entry.
    if ((state_d == ST_VSYNC) && (state_q != ST_VSYNC)) begin
      mode_d  = cam_mode_e'(mode);
      solid_d = solid_color;
    end
  end

  cam_pixel_gen u_pixel_gen (
    .x_i       (COORD_W'(col_d)),
    .y_i       (COORD_W'(line_d)),
    .bar_idx_i (bar_idx_d),
    .mode_i    (mode_q),
    .solid_i   (solid_q),
    .rgb_o     (rgb)
  );

  // Outputs are decoded from the next state/counters and registered, so every
  // output lines up with the cycle in which the FSM occupies that position.
  always_comb begin
    vsync_d = (state_d == ST_VSYNC);
    href_d  = (state_d == ST_ACTIVE) && (byte_d < HREF_END);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_VFRONT) && (line_d == VFRONT_LAST) && (byte_d == BYTE_LAST);
    data_d  = '0;
    if (href_d) begin
      data_d = byte_d[0] ? rgb[7:0] : rgb[15:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      byte_q    <= '0;
      line_q    <= '0;
      col_q     <= '0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      mode_q    <= MODE_BARS;
      solid_q   <= '0;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      line_q    <= line_d;
      col_q     <= col_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      mode_q    <= mode_d;
      solid_q   <= solid_d;
      vsync_q   <= vsync_d;
      href_q    <= href_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign cam_vsync  = vsync_q;
  assign cam_href   = href_q;
  assign cam_data   = data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_cam_pattern_tx.sv
// tb_cam_pattern_tx: self-checking bench for cam_pattern_tx with a small frame
// geometry. A frame-position reference model predicts every output each cycle.
module tb_cam_pattern_tx;

  localparam int unsigned HA = 8;
  localparam int unsigned HB = 2;
  localparam int unsigned VA = 4;
  localparam int unsigned VS = 1;
  localparam int unsigned VB = 1;
  localparam int unsigned VF = 1;
  localparam int unsigned LC = 2 * (HA + HB);
  localparam int unsigned FRAME = (VS + VB + VA + VF) * LC;

  localparam logic [15:0] BAR_TAB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  localparam logic [7:0] BAR_SEQ [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                         8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic        cam_vsync, cam_href, busy, frame_done;
  logic [7:0]  cam_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cam_pattern_tx #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .solid_color(solid_color),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .busy(busy), .frame_done(frame_done)
  );

  // Reference model: whether a frame is running and the cycle offset in it.
  logic        m_run;
  int unsigned m_t;
  logic [1:0]  m_mode;
  logic [15:0] m_solid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0;
      m_t <= 0;
      m_mode <= 2'd0;
      m_solid <= 16'h0;
    end else if (!m_run) begin
      if (enable) begin
        m_run <= 1'b1; m_t <= 0; m_mode <= mode; m_solid <= solid_color;
      end
    end else if (m_t == FRAME - 1) begin
      if (enable) begin
        m_t <= 0; m_mode <= mode; m_solid <= solid_color;
      end else begin
        m_run <= 1'b0;
      end
    end else begin
      m_t <= m_t + 1;
    end
  end

  function automatic logic [15:0] ref_color(input logic [1:0] md, input logic [15:0] sc,
                                            input int unsigned x, input int unsigned y);
    logic [7:0] xb;
    xb = x[7:0];
    case (md)
      2'd0:    return BAR_TAB[x / (HA / 8)];
      2'd1:    return {xb[7:3], xb[7:2], xb[7:3]};
      2'd2:    return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return sc;
    endcase
  endfunction

  // Expected {vsync, href, busy, frame_done, data} for the current model position.
  function automatic logic [11:0] exp_out();
    int unsigned line, b;
    logic [15:0] c;
    logic vs, hr, dn;
    logic [7:0] d;
    if (!m_run) return 12'h000;
    line = m_t / LC;
    b = m_t % LC;
    vs = (line < VS);
    dn = (m_t == FRAME - 1);
    hr = (line >= VS + VB) && (line < VS + VB + VA) && (b < 2 * HA);
    d = 8'h00;
    if (hr) begin
      c = ref_color(m_mode, m_solid, b / 2, line - (VS + VB));
      d = (b % 2 == 1) ? c[7:0] : c[15:8];
    end
    return {vs, hr, 1'b1, dn, d};
  endfunction

  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cam_vsync, cam_href, busy, frame_done, cam_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got=%h expected=000", {cam_vsync, cam_href, busy, frame_done, cam_data});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || cam_vsync !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d busy=%b vsync=%b expected 0/0", i, busy, cam_vsync);
      end
    end
  endtask

  task automatic test_solid();
    int nv, nh, nd;
    logic [7:0] want;
    nv = 0; nh = 0; nd = 0;
    mode = 2'd3; solid_color = 16'hF81F; enable = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({cam_vsync, cam_href, busy, frame_done, cam_data} !== exp_out()) begin
        errors++;
        $display("FAIL solid_model cyc=%0d got=%h expected=%h", i, {cam_vsync, cam_href, busy, frame_done, cam_data}, exp_out());
      end
      if (cam_vsync) nv++;
      if (frame_done) nd++;
      if (cam_href) begin
        want = (nh % 2 == 0) ? 8'hF8 : 8'h1F;
        checks++;
        if (cam_data !== want) begin
          errors++;
          $display("FAIL solid_byte idx=%0d got=%h expected=%h", nh, cam_data, want);
        end
        nh++;
      end
      if (i == FRAME - 1) enable = 1'b0;
    end
    checks++;
    if (nv != 20 || nh != 64 || nd != 1) begin
      errors++;
      $display("FAIL solid_counts vsync=%0d href=%0d done=%0d expected 20/64/1", nv, nh, nd);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL solid_idle busy=%b expected 0", busy);
    end
  endtask

  task automatic test_color_bars();
    mode = 2'd0; enable = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({cam_vsync, cam_href, busy, frame_done, cam_data} !== exp_out()) begin
        errors++;
        $display("FAIL bars_model cyc=%0d got=%h expected=%h", i, {cam_vsync, cam_href, busy, frame_done, cam_data}, exp_out());
      end
      if (i >= 40 && i < 60) begin
        checks++;
        if (i < 56 && (cam_href !== 1'b1 || cam_data !== BAR_SEQ[i-40])) begin
          errors++;
          $display("FAIL bars_byte idx=%0d got href=%b data=%h expected 1/%h", i - 40, cam_href, cam_data, BAR_SEQ[i-40]);
        end else if (i >= 56 && (cam_href !== 1'b0 || cam_data !== 8'h00)) begin
          errors++;
          $display("FAIL bars_blank idx=%0d got href=%b data=%h expected 0/00", i - 40, cam_href, cam_data);
        end
      end
      if (i == 80) begin
        checks++;
        if (cam_data !== 8'hFF) begin
          errors++;
          $display("FAIL bars_after_switch got=%h expected=FF", cam_data);
        end
      end
      // Pattern change in the middle of an active line; must not take effect yet.
      if (i == 70) begin
        mode = 2'd3; solid_color = 16'h1234;
      end
    end
  endtask

  task automatic test_mode_switch();
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({cam_vsync, cam_href, busy, frame_done, cam_data} !== exp_out()) begin
        errors++;
        $display("FAIL switch_model cyc=%0d got=%h expected=%h", i, {cam_vsync, cam_href, busy, frame_done, cam_data}, exp_out());
      end
      if (i == 0 || i == 40 || i == 41) begin
        checks++;
        if ((i == 0 && cam_vsync !== 1'b1) || (i == 40 && cam_data !== 8'h12) || (i == 41 && cam_data !== 8'h34)) begin
          errors++;
          $display("FAIL switch_frame2 cyc=%0d got vsync=%b data=%h expected vsync at 0, 12 at 40, 34 at 41", i, cam_vsync, cam_data);
        end
      end
      if (i == FRAME - 1) enable = 1'b0;
    end
  endtask

  task automatic test_enable_drop();
    mode = 2'($urandom_range(0, 3)); solid_color = 16'($urandom); enable = 1'b1;
    for (int i = 0; i < FRAME + 3; i++) begin
      @(negedge clk);
      checks++;
      if ({cam_vsync, cam_href, busy, frame_done, cam_data} !== exp_out()) begin
        errors++;
        $display("FAIL drop_model cyc=%0d got=%h expected=%h", i, {cam_vsync, cam_href, busy, frame_done, cam_data}, exp_out());
      end
      if (i == 25) enable = 1'b0;
      if (i == FRAME - 1) begin
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL drop_done got done=%b busy=%b expected 1/1", frame_done, busy);
        end
      end
      if (i >= FRAME) begin
        checks++;
        if (busy !== 1'b0 || cam_vsync !== 1'b0) begin
          errors++;
          $display("FAIL drop_idle cyc=%0d busy=%b vsync=%b expected 0/0", i, busy, cam_vsync);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    mode = 2'd1; enable = 1'b1;
    for (int i = 0; i <= 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({cam_vsync, cam_href, busy, frame_done, cam_data} !== exp_out()) begin
        errors++;
        $display("FAIL b2b_model cyc=%0d got=%h expected=%h", i, {cam_vsync, cam_href, busy, frame_done, cam_data}, exp_out());
      end
      if (i == FRAME - 1 || i == FRAME) begin
        checks++;
        if ((i == FRAME - 1 && (frame_done !== 1'b1 || cam_vsync !== 1'b0)) ||
            (i == FRAME && (frame_done !== 1'b0 || cam_vsync !== 1'b1 || busy !== 1'b1))) begin
          errors++;
          $display("FAIL b2b_seam cyc=%0d done=%b vsync=%b busy=%b expected done then vsync", i, frame_done, cam_vsync, busy);
        end
      end
      if (i == 2 * FRAME - 1) enable = 1'b0;
    end
  endtask

  task automatic test_random();
    enable = 1'b1;
    for (int i = 0; i < 3000 + FRAME + 2; i++) begin
      @(negedge clk);
      checks++;
      if ({cam_vsync, cam_href, busy, frame_done, cam_data} !== exp_out()) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%h expected=%h", i, {cam_vsync, cam_href, busy, frame_done, cam_data}, exp_out());
      end
      if (i < 3000) begin
        if ($urandom_range(0, 299) == 0) enable = ~enable;
        if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 59) == 0) solid_color = 16'($urandom);
      end else begin
        enable = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    mode = 2'd0; enable = 1'b1;
    for (int i = 0; i <= 45; i++) begin
      @(negedge clk);
      checks++;
      if ({cam_vsync, cam_href, busy, frame_done, cam_data} !== exp_out()) begin
        errors++;
        $display("FAIL rstmid_model cyc=%0d got=%h expected=%h", i, {cam_vsync, cam_href, busy, frame_done, cam_data}, exp_out());
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cam_vsync, cam_href, busy, frame_done, cam_data} !== 12'h000) begin
      errors++;
      $display("FAIL rstmid_async got=%h expected=000", {cam_vsync, cam_href, busy, frame_done, cam_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FRAME + 1; i++) begin
      @(negedge clk);
      checks++;
      if ({cam_vsync, cam_href, busy, frame_done, cam_data} !== exp_out()) begin
        errors++;
        $display("FAIL rstmid_frame cyc=%0d got=%h expected=%h", i, {cam_vsync, cam_href, busy, frame_done, cam_data}, exp_out());
      end
      if (i == 0) begin
        checks++;
        if (cam_vsync !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL rstmid_restart vsync=%b busy=%b expected 1/1", cam_vsync, busy);
        end
      end
      if (i == FRAME - 1) enable = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_solid();
    test_color_bars();
    test_mode_switch();
    test_enable_drop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
